// File: rtl/alu_i_exec_if.sv
// Handshake/bus bundle for the I-format execute unit: op request side and result side.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; valid never waits on ready, and the sender holds its payload until then.
interface alu_i_exec_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_read;
  logic             mem_write;
  logic             ofl;
  logic             illegal;

  modport master (
    output flush, in_valid, opcode, rs, imm, out_ready,
    input  in_ready, out_valid, rd_data, mem_addr, mem_read, mem_write, ofl, illegal
  );

  modport slave (
    input  flush, in_valid, opcode, rs, imm, out_ready,
    output in_ready, out_valid, rd_data, mem_addr, mem_read, mem_write, ofl, illegal
  );
endinterface

// File: rtl/alu_i_exec.sv
// Registered-result execute unit for I-format ops: ALU ops and mem-address ops finish in one
// edge, shifts/rotates iterate one bit per edge; result held in DONE until taken downstream.
module alu_i_exec #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_i_exec_if.slave bus,
  output logic [1:0] o_dbg_state
);

  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_STU   = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]         r_sh_op, w_sh_op_nxt;
  logic [WIDTH-1:0]   r_rd, w_rd_nxt;
  logic [WIDTH-1:0]   r_addr, w_addr_nxt;
  logic               r_mrd, w_mrd_nxt;
  logic               r_mwr, w_mwr_nxt;
  logic               r_ofl, w_ofl_nxt;
  logic               r_ill, w_ill_nxt;

  logic [WIDTH-1:0]   w_sum_add;
  logic [WIDTH-1:0]   w_sum_sub;
  logic [WIDTH-1:0]   w_rs_n;
  logic               w_ofl_add;
  logic               w_ofl_sub;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_step;

  // SUBI computes imm - rs as imm + ~rs + 1, so its overflow uses imm and ~rs as operands.
  assign w_rs_n    = ~bus.rs;
  assign w_sum_add = bus.rs + bus.imm;
  assign w_sum_sub = bus.imm + w_rs_n + WIDTH'(1);
  assign w_ofl_add = (bus.rs[WIDTH-1] == bus.imm[WIDTH-1]) &&
                     (w_sum_add[WIDTH-1] != bus.rs[WIDTH-1]);
  assign w_ofl_sub = (bus.imm[WIDTH-1] == w_rs_n[WIDTH-1]) &&
                     (w_sum_sub[WIDTH-1] != bus.imm[WIDTH-1]);
  assign w_shamt   = bus.imm[SHAMT_W-1:0];

  // r_sh_op is opcode[1:0]: 00 rotate left, 01 shift left, 10 rotate right, 11 shift right.
  always_comb begin
    w_step = r_rd;
    case (r_sh_op)
      2'b00:   w_step = {r_rd[WIDTH-2:0], r_rd[WIDTH-1]};
      2'b01:   w_step = {r_rd[WIDTH-2:0], 1'b0};
      2'b10:   w_step = {r_rd[0], r_rd[WIDTH-1:1]};
      default: w_step = {1'b0, r_rd[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_op_nxt = r_sh_op;
    w_rd_nxt    = r_rd;
    w_addr_nxt  = r_addr;
    w_mrd_nxt   = r_mrd;
    w_mwr_nxt   = r_mwr;
    w_ofl_nxt   = r_ofl;
    w_ill_nxt   = r_ill;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_rd_nxt    = '0;
          w_addr_nxt  = '0;
          w_mrd_nxt   = 1'b0;
          w_mwr_nxt   = 1'b0;
          w_ofl_nxt   = 1'b0;
          w_ill_nxt   = 1'b0;
          case (bus.opcode)
            OP_ADDI: begin
              w_rd_nxt  = w_sum_add;
              w_ofl_nxt = w_ofl_add;
            end
            OP_SUBI: begin
              w_rd_nxt  = w_sum_sub;
              w_ofl_nxt = w_ofl_sub;
            end
            OP_XORI:  w_rd_nxt = bus.rs ^ bus.imm;
            OP_ANDNI: w_rd_nxt = bus.rs & ~bus.imm;
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
              w_rd_nxt    = bus.rs;
              w_sh_op_nxt = bus.opcode[1:0];
              if (w_shamt != '0) begin
                w_cnt_nxt   = w_shamt;
                w_state_nxt = S_SHIFT;
              end
            end
            OP_ST: begin
              w_addr_nxt = w_sum_add;
              w_mwr_nxt  = 1'b1;
            end
            OP_LD: begin
              w_addr_nxt = w_sum_add;
              w_mrd_nxt  = 1'b1;
            end
            OP_STU: begin
              w_rd_nxt   = w_sum_add;
              w_addr_nxt = w_sum_add;
              w_mwr_nxt  = 1'b1;
            end
            default: w_ill_nxt = 1'b1;
          endcase
        end
      end
      S_SHIFT: begin
        w_rd_nxt = w_step;
        if (r_cnt == SHAMT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - SHAMT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Flush wins over everything except reset, including an op offered in the same cycle.
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_sh_op_nxt = 2'b00;
      w_rd_nxt    = '0;
      w_addr_nxt  = '0;
      w_mrd_nxt   = 1'b0;
      w_mwr_nxt   = 1'b0;
      w_ofl_nxt   = 1'b0;
      w_ill_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh_op <= 2'b00;
      r_rd    <= '0;
      r_addr  <= '0;
      r_mrd   <= 1'b0;
      r_mwr   <= 1'b0;
      r_ofl   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh_op <= w_sh_op_nxt;
      r_rd    <= w_rd_nxt;
      r_addr  <= w_addr_nxt;
      r_mrd   <= w_mrd_nxt;
      r_mwr   <= w_mwr_nxt;
      r_ofl   <= w_ofl_nxt;
      r_ill   <= w_ill_nxt;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.rd_data   = r_rd;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_read  = r_mrd;
  assign bus.mem_write = r_mwr;
  assign bus.ofl       = r_ofl;
  assign bus.illegal   = r_ill;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_i_exec.sv
// Directed bench for alu_i_exec: 16-bit instance for the main vectors, 32-bit instance for
// the wide rotate; expected values are hand-computed constants.
module tb_alu_i_exec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg16;
  logic [1:0] dbg32;
  int         vectors     = 0;
  int         miscompares = 0;
  int         c;
  logic       seen;

  alu_i_exec_if #(.WIDTH(16)) bus16();
  alu_i_exec_if #(.WIDTH(32)) bus32();

  alu_i_exec #(.WIDTH(16), .SHAMT_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .o_dbg_state(dbg16)
  );
  alu_i_exec #(.WIDTH(32), .SHAMT_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .o_dbg_state(dbg32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one op on the 16-bit unit; afterwards scramble inputs to prove they were latched.
  task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    check("send_in_ready", 32'(bus16.in_ready), 32'd1);
    bus16.in_valid = 1'b1;
    bus16.opcode   = op;
    bus16.rs       = a;
    bus16.imm      = b;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    bus16.opcode   = 5'b11111;
    bus16.rs       = ~a;
    bus16.imm      = ~b;
  endtask

  // Count negedges after the accepting edge until out_valid; 1 means right after acceptance.
  task automatic wait_valid(input string tag, input int exp_c);
    int n;
    n = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus16.out_valid) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_c));
  endtask

  task automatic take();
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] rd, input logic [15:0] addr,
                            input logic mrd, input logic mwr, input logic ofl, input logic ill);
    check({tag, "_rd"},   32'(bus16.rd_data),   32'(rd));
    check({tag, "_addr"}, 32'(bus16.mem_addr),  32'(addr));
    check({tag, "_mrd"},  32'(bus16.mem_read),  32'(mrd));
    check({tag, "_mwr"},  32'(bus16.mem_write), 32'(mwr));
    check({tag, "_ofl"},  32'(bus16.ofl),       32'(ofl));
    check({tag, "_ill"},  32'(bus16.illegal),   32'(ill));
  endtask

  initial begin
    bus16.flush = 1'b0; bus16.in_valid = 1'b0; bus16.opcode = '0;
    bus16.rs = '0; bus16.imm = '0; bus16.out_ready = 1'b0;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.opcode = '0;
    bus32.rs = '0; bus32.imm = '0; bus32.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", 32'(bus16.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus16.out_valid), 32'd0);
    check("reset_state", 32'(dbg16), 32'd0);
    check_outs("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    send(5'b01000, 16'h7FFF, 16'h0001);
    wait_valid("addi", 1);
    check_outs("addi", 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    take();

    send(5'b01001, 16'h0005, 16'h0003);
    wait_valid("subi", 1);
    check_outs("subi", 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    take();

    send(5'b01010, 16'h1234, 16'h00FF);
    wait_valid("xori", 1);
    check_outs("xori", 16'h12CB, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    take();

    send(5'b01011, 16'hF0F0, 16'h00FF);
    wait_valid("andni", 1);
    check_outs("andni", 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    take();

    send(5'b10100, 16'h8001, 16'h0004);
    wait_valid("roli4", 5);
    check_outs("roli4", 16'h0018, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    take();

    send(5'b10111, 16'h8000, 16'h0000);
    wait_valid("srli0", 1);
    check("srli0_rd", 32'(bus16.rd_data), 32'h8000);
    take();

    send(5'b10110, 16'h0003, 16'h0001);
    wait_valid("rori1", 2);
    check("rori1_rd", 32'(bus16.rd_data), 32'h8001);
    take();

    send(5'b10101, 16'h00F1, 16'h0003);
    wait_valid("slli3", 4);
    check("slli3_rd", 32'(bus16.rd_data), 32'h0788);
    take();

    send(5'b10111, 16'hF000, 16'h0005);
    wait_valid("srli5", 6);
    check("srli5_rd", 32'(bus16.rd_data), 32'h0780);
    take();

    send(5'b10001, 16'h0100, 16'h0020);
    wait_valid("ld", 1);
    check_outs("ld", 16'h0000, 16'h0120, 1'b1, 1'b0, 1'b0, 1'b0);
    take();

    send(5'b10000, 16'h2000, 16'h0004);
    wait_valid("st", 1);
    check_outs("st", 16'h0000, 16'h2004, 1'b0, 1'b1, 1'b0, 1'b0);
    take();

    send(5'b10011, 16'h1000, 16'hFFFE);
    wait_valid("stu", 1);
    check_outs("stu", 16'h0FFE, 16'h0FFE, 1'b0, 1'b1, 1'b0, 1'b0);
    take();

    send(5'b11111, 16'h1234, 16'h5678);
    wait_valid("illegal", 1);
    check_outs("illegal", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    take();

    // Result held while downstream stalls.
    send(5'b01000, 16'h0001, 16'h0002);
    wait_valid("stall", 1);
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", 32'(bus16.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus16.in_ready), 32'd0);
      check("stall_rd", 32'(bus16.rd_data), 32'h0003);
      @(negedge clk);
    end
    check("stall_state", 32'(dbg16), 32'd2);
    take();
    @(negedge clk);
    check("stall_after_out_valid", 32'(bus16.out_valid), 32'd0);
    check("stall_after_in_ready", 32'(bus16.in_ready), 32'd1);

    // Flush in the third SHIFT cycle of a 15-bit shift.
    send(5'b10101, 16'h0001, 16'h000F);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("flush_pre_state", 32'(dbg16), 32'd1);
    check("flush_pre_rd", 32'(bus16.rd_data), 32'h0004);
    bus16.flush = 1'b1;
    @(posedge clk);
    #1;
    bus16.flush = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(dbg16), 32'd0);
    check("flush_in_ready", 32'(bus16.in_ready), 32'd1);
    check("flush_rd", 32'(bus16.rd_data), 32'h0000);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus16.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_out_valid", 32'(seen), 32'd0);

    // Flush alongside an offered op: the op must be dropped.
    bus16.flush = 1'b1;
    bus16.in_valid = 1'b1;
    bus16.opcode = 5'b01000;
    bus16.rs = 16'h0005;
    bus16.imm = 16'h0005;
    @(posedge clk);
    #1;
    bus16.flush = 1'b0;
    bus16.in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_state", 32'(dbg16), 32'd0);
    check("flush_idle_out_valid", 32'(bus16.out_valid), 32'd0);

    send(5'b01000, 16'h0010, 16'h0020);
    wait_valid("post_flush_addi", 1);
    check("post_flush_addi_rd", 32'(bus16.rd_data), 32'h0030);
    take();

    // Reset in the middle of a shift.
    send(5'b10101, 16'h0001, 16'h000A);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_rd", 32'(bus16.rd_data), 32'h0002);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", 32'(dbg16), 32'd0);
    check("rst_mid_in_ready", 32'(bus16.in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(bus16.out_valid), 32'd0);
    check_outs("rst_mid", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 32-bit instance: RORI by one.
    @(negedge clk);
    bus32.in_valid = 1'b1;
    bus32.opcode = 5'b10110;
    bus32.rs = 32'h0000_0001;
    bus32.imm = 32'h0000_0001;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    bus32.rs = 32'hFFFF_FFFF;
    c = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus32.out_valid) begin
        c = i;
        break;
      end
    end
    check("w32_rori_latency", 32'(c), 32'd2);
    check("w32_rori_rd", bus32.rd_data, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
